// File: rtl/jtframe_debug_view.sv
// Debug value overlay: captures an 8-bit core value once per frame, at
// vblank start, and draws it as two hex digits with a 3x5 font, scaled 2x2,
// over the video stream. A changed value is drawn yellow for 31 frames,
// otherwise white, on a darkened background box.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   pxl_cen               pixel clock enable
//   view_data             value to show (sampled at vblank start)
//   view_en               overlay enable (0 = pass-through, 1 px delay)
//   freeze                hold the shown value
//   rin, gin, bin         core colour in
//   lhbl, lvbl            active-low blanking (1 = active video)
//   rout, gout, bout      registered colour out
module jtframe_debug_view #(
  parameter int unsigned COLORW = 4,
  parameter logic [8:0]  ROW    = 9'd40,
  parameter logic [8:0]  COL    = 9'd128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic [7:0]        view_data,
  input  logic              view_en,
  input  logic              freeze,
  input  logic [COLORW-1:0] rin,
  input  logic [COLORW-1:0] gin,
  input  logic [COLORW-1:0] bin,
  input  logic              lhbl,
  input  logic              lvbl,
  output logic [COLORW-1:0] rout,
  output logic [COLORW-1:0] gout,
  output logic [COLORW-1:0] bout
);

  localparam int unsigned CW  = 9;
  localparam int unsigned HLW = 5;

  logic [CW-1:0]     hcnt, vcnt;
  logic              lhbl_l, lvbl_l;
  logic [7:0]        shown;
  logic [HLW-1:0]    hl_cnt;

  logic [CW-1:0]     dx, dy;
  logic              in_box, pix_on, show;
  logic [3:0]        digit;
  logic [1:0]        gx;
  logic [2:0]        gy;
  logic [14:0]       glyph;
  logic [2:0]        row_bits;
  logic [COLORW-1:0] r_nx, g_nx, b_nx;

  // 3x5 font, one octal digit per row, top row first, MSB = left column
  function automatic logic [14:0] font(input logic [3:0] d);
    case (d)
      4'h0:    font = 15'o75557;
      4'h1:    font = 15'o26227;
      4'h2:    font = 15'o71747;
      4'h3:    font = 15'o71717;
      4'h4:    font = 15'o55711;
      4'h5:    font = 15'o74717;
      4'h6:    font = 15'o74757;
      4'h7:    font = 15'o71111;
      4'h8:    font = 15'o75757;
      4'h9:    font = 15'o75717;
      4'hA:    font = 15'o75755;
      4'hB:    font = 15'o65656;
      4'hC:    font = 15'o74447;
      4'hD:    font = 15'o65556;
      4'hE:    font = 15'o74647;
      default: font = 15'o74644;
    endcase
  endfunction

  // Raster counters and blanking edge detectors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt   <= '0;
      vcnt   <= '0;
      lhbl_l <= 1'b0;
      lvbl_l <= 1'b0;
    end else if (pxl_cen) begin
      lhbl_l <= lhbl;
      lvbl_l <= lvbl;
      hcnt   <= lhbl ? hcnt + CW'(1) : '0;
      if (!lvbl)
        vcnt <= '0;
      else if (lhbl && !lhbl_l)
        vcnt <= vcnt + CW'(1);
    end
  end

  // Frame-synchronous capture; compare uses the value before the update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown  <= '0;
      hl_cnt <= '0;
    end else if (pxl_cen && lvbl_l && !lvbl) begin
      if (!freeze)
        shown <= view_data;
      if (!freeze && view_data != shown)
        hl_cnt <= HLW'(31);
      else if (hl_cnt != '0)
        hl_cnt <= hl_cnt - HLW'(1);
    end
  end

  // Box geometry and glyph lookup; 2x2 screen pixels per font pixel
  always_comb begin
    dx     = hcnt - COL;
    dy     = vcnt - ROW;
    in_box = (dx < CW'(16)) && (dy < CW'(10));
    digit  = dx[3] ? shown[3:0] : shown[7:4];
    gx     = dx[2:1];
    gy     = dy[3:1];
    glyph  = font(digit);
    case (gy)
      3'd0:    row_bits = glyph[14:12];
      3'd1:    row_bits = glyph[11:9];
      3'd2:    row_bits = glyph[8:6];
      3'd3:    row_bits = glyph[5:3];
      default: row_bits = glyph[2:0];
    endcase
    case (gx)
      2'd0:    pix_on = row_bits[2];
      2'd1:    pix_on = row_bits[1];
      2'd2:    pix_on = row_bits[0];
      default: pix_on = 1'b0;   // inter-digit gap
    endcase
    show = view_en && lhbl && lvbl && in_box;
  end

  // Output colour selection
  always_comb begin
    r_nx = rin;
    g_nx = gin;
    b_nx = bin;
    if (show) begin
      if (pix_on) begin
        r_nx = '1;
        g_nx = '1;
        b_nx = (hl_cnt == '0) ? '1 : '0;
      end else begin
        r_nx = rin >> 1;
        g_nx = gin >> 1;
        b_nx = bin >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rout <= '0;
      gout <= '0;
      bout <= '0;
    end else if (pxl_cen) begin
      rout <= r_nx;
      gout <= g_nx;
      bout <= b_nx;
    end
  end

endmodule
